// File: rtl/frame_heartbeat.sv
// frame_heartbeat: frame-rate timebase derived from VGA vsync.
//   Ports:
//     clk              - system clock
//     reset            - synchronous, active-high reset
//     vsync            - asynchronous vsync from the VGA timing generator
//     tapEn            - per-tap enable
//     tapDiv           - per-tap divider, tap i in [i*CNT_W +: CNT_W]
//     keyEvent         - one-cycle pulse that (re)starts the key timer
//     keyTimeoutFrames - key timeout in frames, 0 disables the timer
//     userResetn       - low until RESET_FRAMES ticks have been seen
//     frameTick        - one-cycle pulse per selected vsync edge
//     frameCount       - free-running tick counter
//     tapOut           - per-tap frame-divided square wave
//     keyTimeout       - high once the key timer expires
//     vsyncLost        - high while no tick has been seen for WDOG_CYCLES cycles
`timescale 1ns/1ps

module frame_heartbeat #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned NUM_TAPS     = 4,
  parameter int unsigned RESET_FRAMES = 2,
  parameter int unsigned VSYNC_EDGE   = 0,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WDOG_CYCLES  = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic [NUM_TAPS-1:0]       tapEn,
  input  logic [NUM_TAPS*CNT_W-1:0] tapDiv,
  input  logic                      keyEvent,
  input  logic [CNT_W-1:0]          keyTimeoutFrames,
  output logic                      userResetn,
  output logic                      frameTick,
  output logic [CNT_W-1:0]          frameCount,
  output logic [NUM_TAPS-1:0]       tapOut,
  output logic                      keyTimeout,
  output logic                      vsyncLost
);

  localparam int unsigned BLK_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned BLK_W      = $clog2(BLK_CYCLES + 1);
  localparam int unsigned WDOG_W     = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned RST_W      = (RESET_FRAMES > 0) ? $clog2(RESET_FRAMES + 1) : 1;
  localparam int unsigned KEY_W      = CNT_W + 1;

  typedef enum logic [1:0] {
    KEY_IDLE    = 2'd0,
    KEY_RUN     = 2'd1,
    KEY_EXPIRED = 2'd2
  } keyState_t;

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   vsyncHist;
  logic                   lastSync;
  logic [BLK_W-1:0]       blkCnt;
  logic                   edgeSeen;
  logic                   tickNow;
  logic [RST_W-1:0]       rstCnt;
  logic [RST_W-1:0]       rstCntNext;
  logic [WDOG_W-1:0]      wdogCnt;
  logic [WDOG_W-1:0]      wdogNext;
  logic [CNT_W-1:0]       tapCnt [NUM_TAPS];
  keyState_t              keyState;
  logic [CNT_W-1:0]       keyCnt;
  logic [KEY_W-1:0]       keyCntInc;

  assign lastSync = syncQ[SYNC_STAGES-1];

  // Edge detect, tick qualification and next-state helpers for the counters
  always_comb begin
    edgeSeen   = (VSYNC_EDGE != 0) ? (lastSync & ~vsyncHist) : (~lastSync & vsyncHist);
    // The history flop still holds reset-time zeros for the first few cycles
    tickNow    = edgeSeen && (blkCnt == BLK_W'(BLK_CYCLES));
    rstCntNext = rstCnt;
    if (tickNow && (rstCnt != RST_W'(RESET_FRAMES))) begin
      rstCntNext = rstCnt + RST_W'(1);
    end
    wdogNext = wdogCnt;
    if (frameTick) begin
      wdogNext = '0;
    end else if (wdogCnt != WDOG_W'(WDOG_CYCLES)) begin
      wdogNext = wdogCnt + WDOG_W'(1);
    end
    keyCntInc = {1'b0, keyCnt} + KEY_W'(1);
  end

  // Synchroniser, tick generation, frame counter, user reset and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      syncQ      <= '0;
      vsyncHist  <= 1'b0;
      blkCnt     <= '0;
      frameTick  <= 1'b0;
      frameCount <= '0;
      rstCnt     <= '0;
      userResetn <= 1'b0;
      wdogCnt    <= '0;
      vsyncLost  <= 1'b0;
    end else begin
      syncQ     <= {syncQ[SYNC_STAGES-2:0], vsync};
      vsyncHist <= lastSync;
      if (blkCnt != BLK_W'(BLK_CYCLES)) begin
        blkCnt <= blkCnt + BLK_W'(1);
      end
      frameTick <= tickNow;
      if (tickNow) begin
        frameCount <= frameCount + CNT_W'(1);
      end
      rstCnt     <= rstCntNext;
      userResetn <= (RESET_FRAMES == 0) || (rstCntNext == RST_W'(RESET_FRAMES));
      wdogCnt    <= wdogNext;
      vsyncLost  <= (wdogNext == WDOG_W'(WDOG_CYCLES));
    end
  end

  // Frame-divided toggles; >= lets a shrinking divider take effect on the next tick
  always_ff @(posedge clk) begin
    if (reset) begin
      tapOut <= '0;
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        tapCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        if (!tapEn[i]) begin
          tapCnt[i] <= '0;
          tapOut[i] <= 1'b0;
        end else if (tickNow) begin
          if (tapCnt[i] >= tapDiv[i*CNT_W +: CNT_W]) begin
            tapCnt[i] <= '0;
            tapOut[i] <= ~tapOut[i];
          end else begin
            tapCnt[i] <= tapCnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Key-repeat timer; keyEvent has priority over a coincident tick
  always_ff @(posedge clk) begin
    if (reset) begin
      keyState   <= KEY_IDLE;
      keyCnt     <= '0;
      keyTimeout <= 1'b0;
    end else if (keyEvent) begin
      keyCnt     <= '0;
      keyTimeout <= 1'b0;
      keyState   <= (keyTimeoutFrames == '0) ? KEY_IDLE : KEY_RUN;
    end else begin
      case (keyState)
        KEY_RUN: begin
          if (tickNow) begin
            keyCnt <= keyCntInc[CNT_W-1:0];
            // Live limit: a limit lowered to or below the count expires on this tick
            if (keyCntInc >= {1'b0, keyTimeoutFrames}) begin
              keyTimeout <= 1'b1;
              keyState   <= KEY_EXPIRED;
            end
          end
        end
        KEY_IDLE, KEY_EXPIRED: ;
        default: keyState <= KEY_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_heartbeat.sv
`timescale 1ns/1ps

module tb_frame_heartbeat;

  localparam int CNT_W    = 8;
  localparam int NUM_TAPS = 4;
  localparam int WD       = 50;

  typedef struct packed {
    logic                urn;
    logic                ft;
    logic [CNT_W-1:0]    fc;
    logic [NUM_TAPS-1:0] tap;
    logic                kt;
    logic                lost;
  } obs_t;

  typedef struct packed {
    obs_t i0;
    obs_t i1;
  } pair_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      vsync;
  logic [NUM_TAPS-1:0]       tapEn;
  logic [NUM_TAPS*CNT_W-1:0] tapDiv;
  logic                      keyEvent;
  logic [CNT_W-1:0]          kto;

  logic [1:0]          urn, ft, kt, lost;
  logic [CNT_W-1:0]    fc0, fc1;
  logic [NUM_TAPS-1:0] tap0, tap1;

  always #5 clk = ~clk;

  // Instance 0: falling edge, 2 sync stages, 2 reset frames
  frame_heartbeat #(.CNT_W(CNT_W), .NUM_TAPS(NUM_TAPS), .RESET_FRAMES(2), .VSYNC_EDGE(0),
                    .SYNC_STAGES(2), .WDOG_CYCLES(WD)) u0 (
    .clk(clk), .reset(reset), .vsync(vsync), .tapEn(tapEn), .tapDiv(tapDiv),
    .keyEvent(keyEvent), .keyTimeoutFrames(kto), .userResetn(urn[0]), .frameTick(ft[0]),
    .frameCount(fc0), .tapOut(tap0), .keyTimeout(kt[0]), .vsyncLost(lost[0]));

  // Instance 1: rising edge, 3 sync stages, no reset frames
  frame_heartbeat #(.CNT_W(CNT_W), .NUM_TAPS(NUM_TAPS), .RESET_FRAMES(0), .VSYNC_EDGE(1),
                    .SYNC_STAGES(3), .WDOG_CYCLES(WD)) u1 (
    .clk(clk), .reset(reset), .vsync(vsync), .tapEn(tapEn), .tapDiv(tapDiv),
    .keyEvent(keyEvent), .keyTimeoutFrames(kto), .userResetn(urn[1]), .frameTick(ft[1]),
    .frameCount(fc1), .tapOut(tap1), .keyTimeout(kt[1]), .vsyncLost(lost[1]));

  // Reference model state, one slot per instance
  int ssP [2] = '{2, 3};
  int rfP [2] = '{2, 0};
  int edP [2] = '{0, 1};
  int hs   [2][8];
  int nEdge[2];
  int fcM  [2];
  int rtM  [2];
  int tcM  [2][NUM_TAPS];
  bit toM  [2][NUM_TAPS];
  bit runM [2];
  bit ktM  [2];
  int kcM  [2];
  int wcM  [2];
  bit lastTk[2];

  pair_t expQ[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int holdLeft;

  // Expected outputs after the coming clock edge, from the current inputs
  task automatic modelStep(output pair_t p);
    obs_t oa [2];
    bit tk;
    int cur, prv, dv;
    for (int i = 0; i < 2; i++) begin
      tk = 1'b0;
      if (reset) begin
        for (int k = 0; k < 8; k++) hs[i][k] = 0;
        nEdge[i] = 0; fcM[i] = 0; rtM[i] = 0; runM[i] = 0; ktM[i] = 0;
        kcM[i] = 0; wcM[i] = 0; lastTk[i] = 0;
        for (int t = 0; t < NUM_TAPS; t++) begin tcM[i][t] = 0; toM[i][t] = 0; end
      end else begin
        for (int k = 7; k > 0; k--) hs[i][k] = hs[i][k-1];
        hs[i][0] = int'(vsync);
        if (nEdge[i] < 100) nEdge[i]++;
        cur = hs[i][ssP[i]];
        prv = hs[i][ssP[i]+1];
        if (nEdge[i] >= ssP[i] + 2)
          tk = (edP[i] == 1) ? (cur == 1 && prv == 0) : (cur == 0 && prv == 1);
        if (lastTk[i]) wcM[i] = 0;
        else if (wcM[i] < WD) wcM[i]++;
        if (tk) fcM[i] = (fcM[i] + 1) % 256;
        if (tk && rtM[i] < rfP[i]) rtM[i]++;
        for (int t = 0; t < NUM_TAPS; t++) begin
          dv = int'(tapDiv[t*CNT_W +: CNT_W]);
          if (!tapEn[t]) begin
            tcM[i][t] = 0; toM[i][t] = 0;
          end else if (tk) begin
            if (tcM[i][t] >= dv) begin tcM[i][t] = 0; toM[i][t] = ~toM[i][t]; end
            else tcM[i][t]++;
          end
        end
        if (keyEvent) begin
          kcM[i] = 0; ktM[i] = 0; runM[i] = (kto != 0);
        end else if (runM[i] && tk) begin
          kcM[i]++;
          if (kcM[i] >= int'(kto)) begin ktM[i] = 1; runM[i] = 0; end
        end
        lastTk[i] = tk;
      end
      oa[i].urn  = !reset && (rtM[i] >= rfP[i]);
      oa[i].ft   = tk;
      oa[i].fc   = CNT_W'(fcM[i]);
      for (int t = 0; t < NUM_TAPS; t++) oa[i].tap[t] = toM[i][t];
      oa[i].kt   = ktM[i];
      oa[i].lost = (wcM[i] == WD);
    end
    p.i0 = oa[0];
    p.i1 = oa[1];
  endtask

  task automatic drive(input bit r);
    pair_t p;
    reset = r;
    modelStep(p);
    expQ.push_back(p);
    @(negedge clk);
  endtask

  task automatic runPhase(input int cycles);
    int t;
    for (int c = 0; c < cycles; c++) begin
      if (holdLeft == 0) begin
        vsync = ~vsync;
        holdLeft = ($urandom_range(0, 199) == 0) ? 70 : int'($urandom_range(2, 9));
      end else begin
        holdLeft--;
      end
      keyEvent = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) kto = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 299) == 0) begin
        t = int'($urandom_range(0, NUM_TAPS - 1));
        tapEn[t] = ~tapEn[t];
      end
      for (int k = 0; k < NUM_TAPS; k++)
        if ($urandom_range(0, 99) == 0) tapDiv[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
      drive(1'b0);
    end
  endtask

  // Monitor: every cycle presents a full output set
  always @(posedge clk) begin
    pair_t e;
    obs_t g0, g1;
    #1;
    cyc++;
    if (expQ.size() != 0) begin
      e  = expQ.pop_front();
      g0 = {urn[0], ft[0], fc0, tap0, kt[0], lost[0]};
      g1 = {urn[1], ft[1], fc1, tap1, kt[1], lost[1]};
      checks++;
      if (g0 === e.i0) passes++;
      else $display("FAIL inst0 cyc %0d got urn=%b ft=%b fc=%0d tap=%b kt=%b lost=%b exp urn=%b ft=%b fc=%0d tap=%b kt=%b lost=%b",
                    cyc, g0.urn, g0.ft, g0.fc, g0.tap, g0.kt, g0.lost,
                    e.i0.urn, e.i0.ft, e.i0.fc, e.i0.tap, e.i0.kt, e.i0.lost);
      checks++;
      if (g1 === e.i1) passes++;
      else $display("FAIL inst1 cyc %0d got urn=%b ft=%b fc=%0d tap=%b kt=%b lost=%b exp urn=%b ft=%b fc=%0d tap=%b kt=%b lost=%b",
                    cyc, g1.urn, g1.ft, g1.fc, g1.tap, g1.kt, g1.lost,
                    e.i1.urn, e.i1.ft, e.i1.fc, e.i1.tap, e.i1.kt, e.i1.lost);
    end
  end

  initial begin
    vsync    = 1'b0;
    tapEn    = '0;
    tapDiv   = '0;
    keyEvent = 1'b0;
    kto      = CNT_W'(3);
    holdLeft = 0;
    repeat (3) drive(1'b1);
    tapEn = '1;
    for (int k = 0; k < NUM_TAPS; k++) tapDiv[k*CNT_W +: CNT_W] = CNT_W'(k);
    holdLeft = 80;
    runPhase(1500);
    // Reset mid-run with vsync held high; no tick may follow release
    vsync    = 1'b1;
    keyEvent = 1'b0;
    repeat (4) drive(1'b1);
    holdLeft = 20;
    runPhase(5000);
    keyEvent = 1'b0;
    checks++;
    if (expQ.size() == 0) passes++;
    else $display("FAIL drain got %0d pending exp 0", expQ.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
